// File: rtl/difference_unit_pkg.sv
// Shared constants for the difference unit: state encoding and default widths.
package difference_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/difference_unit_diff_sub.sv
// Combinational WIDTH-bit subtractor: a - b modulo 2^WIDTH plus an unsigned borrow flag.
module diff_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full;

    // The extra top bit goes to 1 exactly when a < b (unsigned).
    assign full   = {1'b0, a} - {1'b0, b};
    assign diff   = full[WIDTH-1:0];
    assign borrow = full[WIDTH];

endmodule

// File: rtl/difference_unit.sv
// Recovers the increment stream from a running-sum stream: y[n] = x[n] - x[n-1] mod 2^WIDTH,
// with valid/ready on both sides and a single registered output stage.
module difference_unit
    import difference_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_borrow,
    output logic             out_first,
    output logic [CNT_W-1:0] sample_cnt
);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             accept;

    diff_sub #(.WIDTH(WIDTH)) u_diff_sub (
        .a      (in_data),
        .b      (prev),
        .diff   (diff),
        .borrow (borrow)
    );

    // The output register may be refilled when empty or when it drains in this same cycle.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_PRIME;
            prev       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_borrow <= 1'b0;
            out_first  <= 1'b0;
            sample_cnt <= '0;
        end else if (clear) begin
            // Restart the chain; a pending result is dropped, the data fields simply hold.
            state      <= ST_PRIME;
            prev       <= '0;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
        end else if (accept) begin
            out_data   <= diff;
            out_borrow <= borrow;
            out_first  <= (state == ST_PRIME);
            out_valid  <= 1'b1;
            prev       <= in_data;
            sample_cnt <= sample_cnt + CNT_W'(1);
            state      <= ST_RUN;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_difference_unit.sv
// Self-checking bench for difference_unit: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_difference_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int MODW  = 1 << WIDTH;
    localparam int MODC  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_borrow;
    logic             out_first;
    logic [CNT_W-1:0] sample_cnt;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Reference model: remembers the last accepted sample and whether the chain is fresh.
    int m_prev = 0;
    bit m_fresh = 1'b1;
    int m_count = 0;
    bit m_valid = 1'b0;
    int m_data = 0;
    bit m_borrow = 1'b0;
    bit m_first = 1'b0;

    difference_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_borrow (out_borrow),
        .out_first  (out_first),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit r, input bit c);
        in_data   = WIDTH'(d);
        in_valid  = v;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_prev = 0; m_fresh = 1'b1; m_count = 0;
            m_valid = 1'b0; m_data = 0; m_borrow = 1'b0; m_first = 1'b0;
        end else begin
            bit rdy;
            int x;
            rdy = !clear && (!m_valid || out_ready);
            x = int'(in_data);
            if (clear) begin
                m_prev = 0; m_fresh = 1'b1; m_count = 0; m_valid = 1'b0;
            end else if (in_valid && rdy) begin
                m_data   = ((x - m_prev) % MODW + MODW) % MODW;
                m_borrow = (x < m_prev);
                m_first  = m_fresh;
                m_fresh  = 1'b0;
                m_prev   = x;
                m_count  = (m_count + 1) % MODC;
                m_valid  = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_in_ready", int'(in_ready), int'(!clear && (!m_valid || out_ready)));
            checkOutput("cyc_out_valid", int'(out_valid), int'(m_valid));
            checkOutput("cyc_out_data", int'(out_data), m_data);
            checkOutput("cyc_out_borrow", int'(out_borrow), int'(m_borrow));
            checkOutput("cyc_out_first", int'(out_first), int'(m_first));
            checkOutput("cyc_sample_cnt", int'(sample_cnt), m_count);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_sample_cnt", int'(sample_cnt), 0);
        checkOutput("rst_out_first", int'(out_first), 0);
        @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Accumulator stream 2,4,6,8,10 gives constant step 2.
        applyStimulus(2, 1, 1, 0);
        checkOutput("acc_latency_valid", int'(out_valid), 1);
        checkOutput("acc_first_data", int'(out_data), 2);
        checkOutput("acc_first_flag", int'(out_first), 1);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(2 * i, 1, 1, 0);
            checkOutput("acc_step_data", int'(out_data), 2);
            checkOutput("acc_step_first", int'(out_first), 0);
        end
        checkOutput("acc_count", int'(sample_cnt), 5);
        applyStimulus(0, 0, 1, 0);
        checkOutput("acc_drain_valid", int'(out_valid), 0);

        // Wrap in both directions.
        applyStimulus(0, 0, 1, 1);
        applyStimulus(250, 1, 1, 0);
        applyStimulus(4, 1, 1, 0);
        checkOutput("wrap_down_data", int'(out_data), 10);
        checkOutput("wrap_down_borrow", int'(out_borrow), 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(4, 1, 1, 0);
        applyStimulus(250, 1, 1, 0);
        checkOutput("wrap_up_data", int'(out_data), 246);
        checkOutput("wrap_up_borrow", int'(out_borrow), 0);

        // Backpressure holds the result and stalls input.
        applyStimulus(0, 0, 1, 1);
        applyStimulus(5, 1, 0, 0);
        applyStimulus(9, 1, 0, 0);
        checkOutput("bp_hold_data", int'(out_data), 5);
        checkOutput("bp_hold_valid", int'(out_valid), 1);
        checkOutput("bp_in_ready", int'(in_ready), 0);
        applyStimulus(9, 1, 1, 0);
        checkOutput("bp_second_data", int'(out_data), 4);
        applyStimulus(0, 0, 1, 0);
        checkOutput("bp_count", int'(sample_cnt), 2);

        // Clear wins over a same-cycle sample.
        applyStimulus(0, 0, 1, 1);
        applyStimulus(10, 1, 1, 0);
        applyStimulus(30, 1, 1, 0);
        applyStimulus(40, 1, 1, 1);
        checkOutput("clr_valid", int'(out_valid), 0);
        checkOutput("clr_count", int'(sample_cnt), 0);
        applyStimulus(40, 1, 1, 0);
        checkOutput("clr_next_data", int'(out_data), 40);
        checkOutput("clr_next_first", int'(out_first), 1);

        // Asynchronous reset between edges with a pending output.
        applyStimulus(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_valid", int'(out_valid), 0);
        checkOutput("arst_data", int'(out_data), 0);
        checkOutput("arst_count", int'(sample_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(7, 1, 1, 0);
        checkOutput("arst_next_data", int'(out_data), 7);
        checkOutput("arst_next_first", int'(out_first), 1);

        // Counter wraps after 256 accepts.
        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 256; i++)
            applyStimulus(int'($urandom_range(0, 255)), 1, 1, 0);
        checkOutput("cnt_wrap", int'(sample_cnt), 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(int'($urandom_range(0, 255)),
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) < 3);
        end
        applyStimulus(0, 0, 1, 0);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/difference_unit.md
Name: difference_unit

Overview:
- Inverse of the team's register-plus-adder accumulator: it recovers the increment stream from a running-sum stream.
- Each output is y[n] = x[n] - x[n-1], computed mod 2^WIDTH. The previous sample is 0 after reset or clear.
- Sits downstream of an accumulator (or any running-sum source). Feeding its outputs back into an accumulator that starts at 0 reproduces the original input stream exactly.
- Valid/ready handshake on both sides, with a single registered output stage.

Parameters:
- WIDTH, 8: data width of samples and differences.
- CNT_W, 8: width of the accepted-sample counter.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset; one clock.
- clear, input, 1: synchronous restart of the difference chain.
- in_data, input, WIDTH: running-sum sample.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block can accept in_data this cycle.
- out_data, output, WIDTH: difference, mod 2^WIDTH.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts out_data.
- out_borrow, output, 1: in_data < previous sample (unsigned), i.e. the running sum wrapped.
- out_first, output, 1: this output is the first after reset or clear (difference taken against 0).
- sample_cnt, output, CNT_W: number of accepted samples since reset or clear; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_data=0, out_valid=0, out_borrow=0, out_first=0, sample_cnt=0.
  - Internal prev=0; state=PRIME.
- States:
  - PRIME: no prior sample held; prev=0.
  - RUN: prev holds the last accepted sample.
  - PRIME -> RUN on the first accept. RUN -> PRIME on clear. Reset forces PRIME from any state.
- in_ready = !clear && (!out_valid || out_ready). It is combinational from registered state and inputs; there is no combinational path from in_valid to in_ready.
- Accept condition: in_valid && in_ready. On the accepting edge:
  - out_data <= in_data - prev (WIDTH bits, borrow discarded).
  - out_borrow <= (in_data < prev).
  - out_first <= (state==PRIME).
  - prev <= in_data.
  - out_valid <= 1.
  - sample_cnt <= sample_cnt+1, wrapping 2^CNT_W-1 -> 0.
  - state <= RUN.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 sample/cycle while out_ready=1.
- Output handshake:
  - A transfer occurs when out_valid && out_ready.
  - If a transfer happens with no new accept in the same cycle, out_valid <= 0.
  - A simultaneous transfer and accept loads the new result with out_valid staying 1.
  - While out_valid && !out_ready, out_data, out_borrow and out_first hold stable, and in_ready=0.
- Clear (clear=1 at a clock edge):
  - prev <= 0, state <= PRIME, sample_cnt <= 0, out_valid <= 0.
  - Any pending output is discarded.
  - Clear has priority over a same-cycle accept; in_ready is 0 during clear, so no sample is taken.
- Mid-operation reset: takes effect immediately (asynchronous), with the same values as above. A pending output is lost.
- First sample after reset or clear: out_data = in_data, out_borrow=0, out_first=1.
- Arithmetic: unsigned modular. Two's-complement interpretation of out_data is the signed step when |step| < 2^(WIDTH-1).

Decomposition:
- Shared package: state encoding constants (ST_PRIME, ST_RUN) and the default WIDTH/CNT_W constants.
- One natural sub-module: diff_sub, a combinational WIDTH-bit subtractor producing the difference and the borrow.
- State, handshake and counters stay in difference_unit.

Test Plan:
- Accumulator stream: after reset, feed 2,4,6,8,10 with out_ready=1 -> out_data 2,2,2,2,2; out_first=1 only on the first output; sample_cnt=5; 1-cycle latency.
- Wrap: feed 250 then 4 -> second out_data=10 with out_borrow=1. Feed 4 then 250 -> second out_data=246 with out_borrow=0.
- Backpressure: feed 5,9 with out_ready=0 -> out_valid=1, out_data=5 held, in_ready=0. Raise out_ready -> 5, then 4. No sample lost or duplicated.
- Clear mid-stream: feed 10,30; assert clear in the same cycle in_valid=1 with 40 -> 40 is not accepted, out_valid=0, sample_cnt=0. Next 40 -> out_data=40, out_first=1.
- Async reset: drop reset between clock edges while out_valid=1 -> all outputs 0 immediately. After release, feed 7 -> out_data=7, out_first=1.
- Counter wrap: 256 accepts with CNT_W=8 -> sample_cnt returns to 0.
